// File: rtl/trace_pkg.sv
// trace_pkg: shared types for the trace buffer controller.
//   state_t    - capture/readout controller state
//   addr_width - address/count width for a given buffer depth
package trace_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        POST,
        DONE,
        READOUT
    } state_t;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/trace_buffer_ctrl_if.sv
// trace_buffer_ctrl_if: readout stream of the trace buffer.
//   io_rd_start - pulse, begin a readout of the frozen buffer
//   io_rd_valid / io_rd_ready / io_rd_data / io_rd_last - valid/ready beat stream
// master: the controller (beat source); slave: the readout consumer.
interface trace_buffer_ctrl_if #(
    parameter int wordWidth = 8
);
    logic                 io_rd_start;
    logic                 io_rd_valid;
    logic                 io_rd_ready;
    logic [wordWidth-1:0] io_rd_data;
    logic                 io_rd_last;

    modport master (
        input  io_rd_start, io_rd_ready,
        output io_rd_valid, io_rd_data, io_rd_last
    );

    modport slave (
        output io_rd_start, io_rd_ready,
        input  io_rd_valid, io_rd_data, io_rd_last
    );
endinterface

// File: rtl/Dpram.sv
// Dpram: dual-port RAM, one clock, 1-cycle registered read on port B.
//   clk                     - clock
//   a_wr / a_adr / a_data   - port A write
//   b_wr / b_adr / b_data   - port B write
//   b_q                     - port B read data, valid the cycle after b_adr
// Contents are not reset.
module Dpram #(
    parameter  int wordCount = 64,
    parameter  int wordWidth = 8,
    localparam int AW        = $clog2(wordCount)
) (
    input  logic                 clk,
    input  logic                 a_wr,
    input  logic [AW-1:0]        a_adr,
    input  logic [wordWidth-1:0] a_data,
    input  logic                 b_wr,
    input  logic [AW-1:0]        b_adr,
    input  logic [wordWidth-1:0] b_data,
    output logic [wordWidth-1:0] b_q
);
    logic [wordWidth-1:0] mem [wordCount];

    always_ff @(posedge clk) begin
        if (a_wr) mem[a_adr] <= a_data;
        if (b_wr) mem[b_adr] <= b_data;
        b_q <= mem[b_adr];
    end
endmodule

// File: rtl/trace_rd_skid.sv
// trace_rd_skid: 2-entry valid/ready skid buffer for RAM read data.
//   clk, rst                    - clock, async active-high reset
//   in_valid / in_data          - push (no backpressure: caller keeps occupancy <= 2)
//   out_valid/out_ready/out_data- registered output stream
//   count                       - current occupancy (0..2)
// Output data comes straight from a storage register, so it holds
// steady while the consumer stalls.
module trace_rd_skid #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);
    logic [W-1:0] slot [2];
    logic         wr_idx;
    logic         rd_idx;
    logic [1:0]   cnt;
    logic         pop;

    assign out_valid = (cnt != 2'd0);
    assign out_data  = slot[rd_idx];
    assign count     = cnt;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_idx  <= 1'b0;
            rd_idx  <= 1'b0;
            cnt     <= 2'd0;
        end else begin
            if (in_valid) begin
                slot[wr_idx] <= in_data;
                wr_idx       <= ~wr_idx;
            end
            if (pop) rd_idx <= ~rd_idx;
            cnt <= cnt + 2'(in_valid) - 2'(pop);
        end
    end
endmodule

// File: rtl/trace_buffer_ctrl.sv
// trace_buffer_ctrl: circular trace capture over a Dpram.
//   io_clk, io_reset       - clock, async active-high reset
//   io_arm                 - pulse: restart capture (IDLE/DONE only)
//   io_sample_valid/_data  - incoming sample stream (port A writes)
//   io_trigger             - trigger qualifier, with io_sample_valid
//   io_post_count          - samples stored after the trigger sample
//   io_capturing/io_triggered/io_done/io_wrapped - status
//   rd                     - readout stream (start pulse + valid/ready beats)
// Readout drains the frozen buffer oldest-first; the buffer is kept so it
// can be read again.
module trace_buffer_ctrl import trace_pkg::*; #(
    parameter  int wordCount = 64,
    parameter  int wordWidth = 8,
    localparam int AW        = addr_width(wordCount)
) (
    input  logic                 io_clk,
    input  logic                 io_reset,
    input  logic                 io_arm,
    input  logic                 io_sample_valid,
    input  logic [wordWidth-1:0] io_sample_data,
    input  logic                 io_trigger,
    input  logic [AW-1:0]        io_post_count,
    output logic                 io_capturing,
    output logic                 io_triggered,
    output logic                 io_done,
    output logic                 io_wrapped,
    trace_buffer_ctrl_if.master  rd
);
    state_t               state, state_nxt;
    logic [AW-1:0]        wr_ptr, rd_ptr, remaining, oldest;
    logic [AW:0]          beats_left, stored_n;
    logic                 inflight, inflight_last;
    logic [1:0]           skid_cnt;
    logic                 skid_valid, skid_last;
    logic [wordWidth-1:0] skid_data, ram_q;
    logic                 wr_en, arm_ok, start_ok, rd_issue, pop, last_pop;
    logic [2:0]           occ_after;

    assign stored_n  = io_wrapped ? (AW+1)'(wordCount) : {1'b0, wr_ptr};
    assign oldest    = io_wrapped ? wr_ptr : '0;
    assign pop       = skid_valid && rd.io_rd_ready;
    assign last_pop  = pop && skid_last;
    // Slots that will be taken next cycle if nothing new is issued: the
    // read now in flight lands in the skid, minus whatever leaves this cycle.
    assign occ_after = 3'(inflight) + 3'(skid_cnt) - 3'(pop);

    // ---- state register
    always_ff @(posedge io_clk or posedge io_reset) begin
        if (io_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    // ---- next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (io_arm) state_nxt = CAPTURE;
            CAPTURE: if (io_sample_valid && io_trigger)
                         state_nxt = (io_post_count == '0) ? DONE : POST;
            POST:    if (io_sample_valid && remaining == AW'(1)) state_nxt = DONE;
            DONE:    if (io_arm)               state_nxt = CAPTURE;
                     else if (rd.io_rd_start)  state_nxt = READOUT;
            READOUT: if (last_pop) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- state-decoded outputs and strobes
    always_comb begin
        io_capturing = 1'b0;
        io_done      = 1'b0;
        arm_ok       = 1'b0;
        start_ok     = 1'b0;
        rd_issue     = 1'b0;
        unique case (state)
            IDLE:    arm_ok = io_arm;
            CAPTURE,
            POST:    io_capturing = 1'b1;
            DONE: begin
                io_done  = 1'b1;
                arm_ok   = io_arm;
                start_ok = !io_arm && rd.io_rd_start;
            end
            READOUT: begin
                io_done  = 1'b1;
                rd_issue = (beats_left != '0) && (occ_after < 3'd2);
            end
            default: ;
        endcase
        wr_en = io_capturing && io_sample_valid;
    end

    // ---- pointers, counters, sticky flags
    always_ff @(posedge io_clk or posedge io_reset) begin
        if (io_reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            remaining     <= '0;
            beats_left    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            io_wrapped    <= 1'b0;
            io_triggered  <= 1'b0;
        end else begin
            if (arm_ok) begin
                wr_ptr       <= '0;
                io_wrapped   <= 1'b0;
                io_triggered <= 1'b0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (wr_ptr == AW'(wordCount - 1)) io_wrapped <= 1'b1;
                if (state == CAPTURE && io_trigger) begin
                    io_triggered <= 1'b1;
                    remaining    <= io_post_count;
                end else if (state == POST) begin
                    remaining <= remaining - AW'(1);
                end
            end

            if (start_ok) begin
                rd_ptr     <= oldest;
                beats_left <= stored_n;
            end else if (rd_issue) begin
                rd_ptr     <= rd_ptr + AW'(1);
                beats_left <= beats_left - (AW+1)'(1);
            end

            // Track the read whose data appears on ram_q next cycle.
            inflight      <= rd_issue;
            inflight_last <= rd_issue && (beats_left == (AW+1)'(1));
        end
    end

    Dpram #(
        .wordCount(wordCount),
        .wordWidth(wordWidth)
    ) u_ram (
        .clk    (io_clk),
        .a_wr   (wr_en),
        .a_adr  (wr_ptr),
        .a_data (io_sample_data),
        .b_wr   (1'b0),
        .b_adr  (rd_ptr),
        .b_data ('0),
        .b_q    (ram_q)
    );

    trace_rd_skid #(
        .W(wordWidth + 1)
    ) u_skid (
        .clk       (io_clk),
        .rst       (io_reset),
        .in_valid  (inflight),
        .in_data   ({inflight_last, ram_q}),
        .out_valid (skid_valid),
        .out_ready (rd.io_rd_ready),
        .out_data  ({skid_last, skid_data}),
        .count     (skid_cnt)
    );

    assign rd.io_rd_valid = skid_valid;
    assign rd.io_rd_data  = skid_data;
    assign rd.io_rd_last  = skid_last;
endmodule

// File: tb/tb_trace_buffer_ctrl.sv
// tb_trace_buffer_ctrl: directed bench for trace_buffer_ctrl (8 x 8).
// A behavioural model of the capture side predicts buffer contents; each
// readout pushes the expected beats into a queue that a monitor drains.
module tb_trace_buffer_ctrl;
    localparam int WC = 8;
    localparam int WW = 8;
    localparam int AW = 3;

    localparam int M_IDLE = 0, M_CAP = 1, M_POST = 2, M_DONE = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          arm, sv, trig;
    logic [WW-1:0] sd;
    logic [AW-1:0] post;
    logic          capturing, triggered, done, wrapped;

    trace_buffer_ctrl_if #(.wordWidth(WW)) rd_bus ();

    trace_buffer_ctrl #(
        .wordCount(WC),
        .wordWidth(WW)
    ) dut (
        .io_clk          (clk),
        .io_reset        (reset),
        .io_arm          (arm),
        .io_sample_valid (sv),
        .io_sample_data  (sd),
        .io_trigger      (trig),
        .io_post_count   (post),
        .io_capturing    (capturing),
        .io_triggered    (triggered),
        .io_done         (done),
        .io_wrapped      (wrapped),
        .rd              (rd_bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input logic [31:0] obs, input logic [31:0] want, input string tag);
        n_chk++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    // ---- capture model
    logic [WW-1:0] m_mem [WC];
    int            m_wp, m_rem, m_state;
    bit            m_wrapped, m_trig;

    logic [WW:0]   exp_q [$];

    task automatic model_reset();
        m_state = M_IDLE; m_wp = 0; m_rem = 0; m_wrapped = 0; m_trig = 0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        if (m_state == M_IDLE || m_state == M_DONE) begin
            m_state = M_CAP; m_wp = 0; m_wrapped = 0; m_trig = 0;
        end
    endtask

    task automatic sample(input logic [WW-1:0] d, input bit t, input int p);
        sv = 1'b1; sd = d; trig = t; post = AW'(p);
        @(posedge clk); #1;
        sv = 1'b0; trig = 1'b0;
        if (m_state == M_CAP || m_state == M_POST) begin
            m_mem[m_wp] = d;
            if (m_wp == WC - 1) m_wrapped = 1;
            m_wp = (m_wp + 1) % WC;
            if (m_state == M_CAP && t) begin
                m_trig = 1;
                if (p == 0) m_state = M_DONE;
                else begin m_rem = p; m_state = M_POST; end
            end else if (m_state == M_POST) begin
                m_rem--;
                if (m_rem == 0) m_state = M_DONE;
            end
        end
    endtask

    // Expected beats go into the queue at start; the ready pattern
    // 1,0,1,0,0,1 is used for backpressure runs.
    task automatic readout(input bit bp, input bit chk_lat, input bit arm_mid, input string tag);
        int n, oldest, cyc;
        logic [5:0] pat;
        pat = 6'b100101;  // bit k = ready for cycle k
        n      = m_wrapped ? WC : m_wp;
        oldest = m_wrapped ? m_wp : 0;
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == n - 1), m_mem[(oldest + i) % WC]});
        rd_bus.io_rd_ready = 1'b1;
        rd_bus.io_rd_start = 1'b1;
        @(posedge clk); #1;
        rd_bus.io_rd_start = 1'b0;
        if (chk_lat) begin
            @(negedge clk); chk(rd_bus.io_rd_valid, 0, {tag, "_lat1"});
            @(negedge clk); chk(rd_bus.io_rd_valid, 0, {tag, "_lat2"});
            @(negedge clk); chk(rd_bus.io_rd_valid, 1, {tag, "_lat3"});
        end
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (bp) rd_bus.io_rd_ready = pat[cyc % 6];
            arm = (arm_mid && cyc == 2);
        end
        arm = 1'b0;
        rd_bus.io_rd_ready = 1'b1;
        chk(exp_q.size(), 0, {tag, "_drained"});
        if (chk_lat) chk(cyc, n, {tag, "_rate"});
        chk({capturing, done, rd_bus.io_rd_valid}, 3'b010, {tag, "_back_done"});
        exp_q.delete();
    endtask

    // ---- output monitor: scoreboard pop and stall stability
    logic          p_valid, p_ready, p_last;
    logic [WW-1:0] p_data;

    always @(negedge clk) begin
        if (reset) begin
            p_valid = 1'b0;
        end else begin
            if (p_valid && !p_ready)
                chk({rd_bus.io_rd_valid, rd_bus.io_rd_last, rd_bus.io_rd_data},
                    {1'b1, p_last, p_data}, "stall_hold");
            if (rd_bus.io_rd_valid && rd_bus.io_rd_ready) begin
                chk(exp_q.size() != 0, 1, "no_extra_beat");
                if (exp_q.size() != 0)
                    chk({rd_bus.io_rd_last, rd_bus.io_rd_data}, exp_q.pop_front(), "beat");
            end
            p_valid = rd_bus.io_rd_valid;
            p_ready = rd_bus.io_rd_ready;
            p_last  = rd_bus.io_rd_last;
            p_data  = rd_bus.io_rd_data;
        end
    end

    task automatic chk_status(input string tag);
        chk({capturing, triggered, done, wrapped},
            {(m_state == M_CAP || m_state == M_POST), m_trig, (m_state == M_DONE), m_wrapped},
            tag);
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; sv = 1'b0; trig = 1'b0; sd = '0; post = '0;
        rd_bus.io_rd_start = 1'b0; rd_bus.io_rd_ready = 1'b1;
        p_valid = 1'b0; p_ready = 1'b0; p_last = 1'b0; p_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk({capturing, triggered, done, wrapped, rd_bus.io_rd_valid,
             rd_bus.io_rd_last, rd_bus.io_rd_data}, 0, "reset_outs");
        reset = 1'b0;
        @(posedge clk); #1;

        // 1. basic capture
        do_arm();
        chk_status("t1_armed");
        sample(8'h10, 0, 2); sample(8'h11, 0, 2); sample(8'h12, 0, 2);
        sample(8'h13, 1, 2);
        chk_status("t1_post");
        sample(8'h14, 0, 0);
        chk_status("t1_post2");
        sample(8'h15, 0, 0);
        chk_status("t1_done");
        sample(8'h99, 1, 0);  // dropped in DONE
        readout(0, 1, 0, "t1_rd");

        // 2. wrap
        do_arm();
        for (int i = 0; i < 20; i++) sample(WW'(i), (i == 15), 4);
        chk_status("t2_done");
        readout(0, 0, 0, "t2_rd");

        // 3. trigger without valid, then zero post count
        do_arm();
        trig = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0;
        chk(triggered, 0, "t3_trig_novalid");
        sample(8'hAA, 1, 0);
        chk_status("t3_done");
        readout(0, 0, 0, "t3_rd");

        // 4. backpressure and replay
        do_arm();
        sample(8'h10, 0, 2); sample(8'h11, 0, 2); sample(8'h12, 0, 2);
        sample(8'h13, 1, 2); sample(8'h14, 0, 0); sample(8'h15, 0, 0);
        chk_status("t4_done");
        readout(1, 0, 0, "t4_rd1");
        readout(1, 0, 0, "t4_rd2");

        // 5. reset in POST, re-arm, arm ignored during readout
        do_arm();
        sample(8'h20, 1, 3); sample(8'h21, 0, 3);
        chk_status("t5_in_post");
        reset = 1'b1;
        #1;
        chk({capturing, triggered, done, wrapped, rd_bus.io_rd_valid,
             rd_bus.io_rd_last, rd_bus.io_rd_data}, 0, "t5_reset_outs");
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk_status("t5_idle");
        do_arm();
        chk_status("t5_rearmed");
        sample(8'h30, 0, 1); sample(8'h31, 1, 1); sample(8'h32, 0, 1);
        chk_status("t5_done");
        readout(0, 0, 1, "t5_rd");
        chk_status("t5_after_arm");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
